// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered sign/zero extension stage for the MIPS datapath.
// It covers the ID-stage immediate forms (SE16, ZE16, LUI) and the MEM/WB
// load-data forms (LB, LBU, LH, LHU), plus a PASS mode.
// Timing: one cycle of latency behind a valid/ready handshake. A one-entry
// skid register keeps full throughput when the consumer applies backpressure.
// Optional feature: define EXT_ALIGN_CHK_EN to add out_align_err. It flags
// halfword loads that use an odd byte offset, and the flag travels with its beat.
module ext_unit_pipe #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef EXT_ALIGN_CHK_EN
  ,
  output logic              out_align_err
`endif
);

  // Build the extended result from one input beat.
  // Lanes are little-endian. Halfword loads ignore off[0].
  function automatic logic [DATA_W-1:0] extend(
    input logic [2:0]        mode,
    input logic [DATA_W-1:0] data,
    input logic [OFF_W-1:0]  off
  );
    logic [OFF_W+2:0]  byte_shift;
    logic [OFF_W+2:0]  half_shift;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] res;
    byte_shift = {off, 3'b000};
    half_shift = {off[OFF_W-1:1], 4'b0000};
    byte_lane  = 8'(data >> byte_shift);
    half_lane  = 16'(data >> half_shift);
    case (mode)
      3'd0:    res = {{(DATA_W-16){data[15]}}, data[15:0]};
      3'd1:    res = {{(DATA_W-16){1'b0}}, data[15:0]};
      3'd2:    res = {data[15:0], {(DATA_W-16){1'b0}}};
      3'd3:    res = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      3'd4:    res = {{(DATA_W-8){1'b0}}, byte_lane};
      3'd5:    res = {{(DATA_W-16){half_lane[15]}}, half_lane};
      3'd6:    res = {{(DATA_W-16){1'b0}}, half_lane};
      3'd7:    res = data;
      default: res = data;
    endcase
    return res;
  endfunction

  // Pipeline state: output register (or_*) and skid register (sk_*).
  logic              or_valid_r;
  logic [DATA_W-1:0] or_data_r;
  logic              sk_valid_r;
  logic [DATA_W-1:0] sk_data_r;
  logic              in_ready_r;

  // Next-state values.
  logic              or_valid_nxt_s;
  logic [DATA_W-1:0] or_data_nxt_s;
  logic              sk_valid_nxt_s;
  logic [DATA_W-1:0] sk_data_nxt_s;

  logic              in_xfer_s;
  logic              or_free_s;
  logic [DATA_W-1:0] result_s;

`ifdef EXT_ALIGN_CHK_EN
  logic or_err_r;
  logic sk_err_r;
  logic or_err_nxt_s;
  logic sk_err_nxt_s;
  logic result_err_s;

  // A halfword load with an odd byte offset is misaligned.
  always_comb begin
    result_err_s = 1'b0;
    if ((in_mode == 3'd5) || (in_mode == 3'd6)) begin
      result_err_s = in_off[0];
    end else begin
      result_err_s = 1'b0;
    end
  end
`endif

  assign in_xfer_s = in_valid & in_ready_r;
  // The OR can take a new entry when it is empty or when it is draining this cycle.
  assign or_free_s = ~or_valid_r | out_ready;
  assign result_s  = extend(in_mode, in_data, in_off);

  // Next-state logic. Priority for the OR is skid entry, then the new beat, then empty.
  always_comb begin
    or_valid_nxt_s = or_valid_r;
    or_data_nxt_s  = or_data_r;
    sk_valid_nxt_s = sk_valid_r;
    sk_data_nxt_s  = sk_data_r;
`ifdef EXT_ALIGN_CHK_EN
    or_err_nxt_s   = or_err_r;
    sk_err_nxt_s   = sk_err_r;
`endif
    if (or_free_s) begin
      if (sk_valid_r) begin
        or_valid_nxt_s = 1'b1;
        or_data_nxt_s  = sk_data_r;
        sk_valid_nxt_s = 1'b0;
`ifdef EXT_ALIGN_CHK_EN
        or_err_nxt_s   = sk_err_r;
`endif
      end else if (in_xfer_s) begin
        or_valid_nxt_s = 1'b1;
        or_data_nxt_s  = result_s;
`ifdef EXT_ALIGN_CHK_EN
        or_err_nxt_s   = result_err_s;
`endif
      end else begin
        // Data is kept so that out_data holds its last value while idle.
        or_valid_nxt_s = 1'b0;
      end
    end else if (in_xfer_s) begin
      // The OR is stalled, so the accepted beat parks in the skid register.
      sk_valid_nxt_s = 1'b1;
      sk_data_nxt_s  = result_s;
`ifdef EXT_ALIGN_CHK_EN
      sk_err_nxt_s   = result_err_s;
`endif
    end else begin
      sk_valid_nxt_s = sk_valid_r;
    end
  end

  // State registers. in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_valid_r <= 1'b0;
      or_data_r  <= '0;
      sk_valid_r <= 1'b0;
      sk_data_r  <= '0;
      in_ready_r <= 1'b1;
    end else begin
      or_valid_r <= or_valid_nxt_s;
      or_data_r  <= or_data_nxt_s;
      sk_valid_r <= sk_valid_nxt_s;
      sk_data_r  <= sk_data_nxt_s;
      in_ready_r <= ~sk_valid_nxt_s;
    end
  end

`ifdef EXT_ALIGN_CHK_EN
  // Misalignment flags travel alongside their beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_err_r <= 1'b0;
      sk_err_r <= 1'b0;
    end else begin
      or_err_r <= or_err_nxt_s;
      sk_err_r <= sk_err_nxt_s;
    end
  end

  assign out_align_err = or_err_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = or_valid_r;
  assign out_data  = or_data_r;

endmodule
